// File: rtl/calc_pkg.sv
// Shared constants and types for the two-digit decimal calculator sequencer.
package calc_pkg;

    localparam int unsigned OPD_W_DEF = 7;
    localparam int unsigned RES_W_DEF = 14;
    localparam int unsigned BCD_N_DEF = 4;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    typedef enum logic [2:0] {StEntA, StEntB, StCalc, StConv, StDone, StErr} state_e;

    // Operator keys are contiguous, so the offset from KEY_ADD is the op encoding.
    function automatic op_e key_to_op(input logic [3:0] code);
        logic [3:0] diff;
        diff = code - KEY_ADD;
        return op_e'(diff[1:0]);
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter: one shift per cycle for Width cycles after start_i.
// bcd_o carries the digits produced by the current step and is final while done_o is high.
module calc_bin2bcd #(
    parameter int unsigned Width  = 14,
    parameter int unsigned Digits = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [Width-1:0]      bin_i,
    output logic                  done_o,
    output logic [4*Digits-1:0]   bcd_o
);
    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width-1:0]          bin_q, bin_d;
    logic [4*Digits-1:0]       bcd_q, bcd_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      run_q, run_d;
    logic [4*Digits-1:0]       bcd_adj;
    logic [4*Digits+Width-1:0] shifted;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(Digits); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CntW'(Width);
            run_d = 1'b1;
        end else if (run_q) begin
            bin_d = shifted[Width-1:0];
            bcd_d = shifted[4*Digits+Width-1:Width];
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CntW'(1));
    assign bcd_o  = shifted[4*Digits+Width-1:Width];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the two-digit calculator: operand entry, ALU/divider, BCD result.
// Define CALC_REMAINDER_EN to add rem_d1/rem_d0 carrying the BCD division remainder.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned OPD_W = OPD_W_DEF,
    parameter int unsigned RES_W = RES_W_DEF,
    parameter int unsigned BCD_N = BCD_N_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [3:0] res_d3,
    output logic [3:0] res_d2,
    output logic [3:0] res_d1,
    output logic [3:0] res_d0,
    output logic       res_neg,
    output logic       res_valid,
    output logic       err,
    output logic       busy
`ifdef CALC_REMAINDER_EN
    ,
    output logic [3:0] rem_d1,
    output logic [3:0] rem_d0
`endif
);
    localparam int unsigned DivCntW = $clog2(OPD_W);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [OPD_W-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [1:0]           na_q, na_d, nb_q, nb_d;
    logic [RES_W-1:0]     result_q, result_d;
    logic                 neg_q, neg_d, res_neg_q, res_neg_d;
    logic                 res_valid_q, res_valid_d, err_q, err_d;
    logic [4*BCD_N-1:0]   dig_q, dig_d;
    logic [OPD_W-1:0]     div_quo_q, div_quo_d, div_rem_q, div_rem_d;
    logic [DivCntW-1:0]   div_cnt_q, div_cnt_d;

    logic                 key_hit, clr_hit, key_is_digit, key_is_op, key_is_eq;
    logic [OPD_W-1:0]     key_digit;
    logic [OPD_W:0]       div_trial;
    logic                 div_ge;
    logic [OPD_W-1:0]     div_rem_next, div_quo_next;
    logic [RES_W-1:0]     alu_res;
    logic                 alu_neg;
    logic                 conv_rst, conv_start, conv_done, enter_done, enter_err;
    logic [RES_W-1:0]     conv_bin;
    logic [4*BCD_N-1:0]   conv_bcd;

    assign key_ready    = (state_q == StEntA) || (state_q == StEntB) ||
                          (state_q == StDone) || (state_q == StErr);
    assign busy         = (state_q == StCalc) || (state_q == StConv);
    assign key_hit      = key_valid && key_ready;
    assign clr_hit      = key_valid && (key_code == KEY_CLR);
    assign key_is_digit = key_code <= 4'd9;
    assign key_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign key_is_eq    = key_code == KEY_EQ;
    assign key_digit    = OPD_W'(key_code);

    // One restoring shift-subtract step: quotient bits shift in from the right.
    assign div_trial    = {div_rem_q, div_quo_q[OPD_W-1]};
    assign div_ge       = div_trial >= {1'b0, opb_q};
    assign div_rem_next = div_ge ? OPD_W'(div_trial - {1'b0, opb_q}) : div_trial[OPD_W-1:0];
    assign div_quo_next = {div_quo_q[OPD_W-2:0], div_ge};

    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        unique case (op_q)
            OP_ADD: alu_res = RES_W'(opa_q) + RES_W'(opb_q);
            OP_SUB: begin
                if (opa_q < opb_q) begin
                    alu_res = RES_W'(opb_q - opa_q);
                    alu_neg = 1'b1;
                end else begin
                    alu_res = RES_W'(opa_q - opb_q);
                end
            end
            OP_MUL: alu_res = RES_W'(opa_q) * RES_W'(opb_q);
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        na_d        = na_q;
        nb_d        = nb_q;
        result_d    = result_q;
        neg_d       = neg_q;
        res_neg_d   = res_neg_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
        dig_d       = dig_q;
        div_quo_d   = div_quo_q;
        div_rem_d   = div_rem_q;
        div_cnt_d   = div_cnt_q;
        conv_start  = 1'b0;
        conv_bin    = '0;

        unique case (state_q)
            StEntA: begin
                if (key_hit && key_is_digit && (na_q < 2'd2)) begin
                    opa_d = opa_q * OPD_W'(10) + key_digit;
                    na_d  = na_q + 2'd1;
                end else if (key_hit && key_is_op) begin
                    op_d    = key_to_op(key_code);
                    opb_d   = '0;
                    nb_d    = '0;
                    state_d = StEntB;
                end
            end
            StEntB: begin
                if (key_hit && key_is_digit && (nb_q < 2'd2)) begin
                    opb_d = opb_q * OPD_W'(10) + key_digit;
                    nb_d  = nb_q + 2'd1;
                end else if (key_hit && key_is_op) begin
                    op_d = key_to_op(key_code);
                end else if (key_hit && key_is_eq) begin
                    div_quo_d = opa_q;
                    div_rem_d = '0;
                    div_cnt_d = '0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (op_q != OP_DIV) begin
                    result_d   = alu_res;
                    neg_d      = alu_neg;
                    conv_start = 1'b1;
                    conv_bin   = alu_res;
                    state_d    = StConv;
                end else if (opb_q == '0) begin
                    err_d     = 1'b1;
                    dig_d     = '0;
                    res_neg_d = 1'b0;
                    state_d   = StErr;
                end else begin
                    div_quo_d = div_quo_next;
                    div_rem_d = div_rem_next;
                    div_cnt_d = div_cnt_q + DivCntW'(1);
                    if (div_cnt_q == DivCntW'(OPD_W - 1)) begin
                        result_d   = RES_W'(div_quo_next);
                        neg_d      = 1'b0;
                        conv_start = 1'b1;
                        conv_bin   = RES_W'(div_quo_next);
                        state_d    = StConv;
                    end
                end
            end
            StConv: begin
                if (conv_done) begin
                    dig_d       = conv_bcd;
                    res_neg_d   = neg_q;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (key_hit && key_is_digit) begin
                    opa_d   = key_digit;
                    na_d    = 2'd1;
                    opb_d   = '0;
                    nb_d    = '0;
                    state_d = StEntA;
                end else if (key_hit && key_is_op) begin
                    if (result_q <= RES_W'(99)) begin
                        opa_d   = result_q[OPD_W-1:0];
                        na_d    = 2'd2;
                        op_d    = key_to_op(key_code);
                        opb_d   = '0;
                        nb_d    = '0;
                        state_d = StEntB;
                    end else begin
                        err_d     = 1'b1;
                        dig_d     = '0;
                        res_neg_d = 1'b0;
                        state_d   = StErr;
                    end
                end
            end
            StErr: ;
            default: state_d = StEntA;
        endcase

        // Clear wins over everything, including a busy datapath.
        if (clr_hit) begin
            state_d     = StEntA;
            op_d        = OP_ADD;
            opa_d       = '0;
            opb_d       = '0;
            na_d        = '0;
            nb_d        = '0;
            result_d    = '0;
            neg_d       = 1'b0;
            res_neg_d   = 1'b0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
            dig_d       = '0;
            div_quo_d   = '0;
            div_rem_d   = '0;
            div_cnt_d   = '0;
            conv_start  = 1'b0;
        end
    end

    assign enter_done = (state_q == StConv) && conv_done;
    assign enter_err  = (state_d == StErr) && (state_q != StErr);
    assign conv_rst   = rst || clr_hit;

    calc_bin2bcd #(
        .Width (RES_W),
        .Digits(BCD_N)
    ) u_res_conv (
        .clk_i  (clk),
        .rst_i  (conv_rst),
        .start_i(conv_start),
        .bin_i  (conv_bin),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEntA;
            op_q        <= OP_ADD;
            opa_q       <= '0;
            opb_q       <= '0;
            na_q        <= '0;
            nb_q        <= '0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            res_neg_q   <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            dig_q       <= '0;
            div_quo_q   <= '0;
            div_rem_q   <= '0;
            div_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            na_q        <= na_d;
            nb_q        <= nb_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            res_neg_q   <= res_neg_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            dig_q       <= dig_d;
            div_quo_q   <= div_quo_d;
            div_rem_q   <= div_rem_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    assign res_d3    = dig_q[15:12];
    assign res_d2    = dig_q[11:8];
    assign res_d1    = dig_q[7:4];
    assign res_d0    = dig_q[3:0];
    assign res_neg   = res_neg_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

`ifdef CALC_REMAINDER_EN
    logic [RES_W-1:0] rem_bin;
    logic             rem_done;
    logic [7:0]       rem_bcd;
    logic [7:0]       rem_dig_q, rem_dig_d;

    // Runs alongside the result converter with the same length, so both finish together.
    assign rem_bin = (op_q == OP_DIV) ? RES_W'(div_rem_next) : '0;

    calc_bin2bcd #(
        .Width (RES_W),
        .Digits(2)
    ) u_rem_conv (
        .clk_i  (clk),
        .rst_i  (conv_rst),
        .start_i(conv_start),
        .bin_i  (rem_bin),
        .done_o (rem_done),
        .bcd_o  (rem_bcd)
    );

    always_comb begin
        rem_dig_d = rem_dig_q;
        if (clr_hit || enter_err) begin
            rem_dig_d = '0;
        end else if (rem_done && enter_done) begin
            rem_dig_d = rem_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_dig_q <= '0;
        end else begin
            rem_dig_q <= rem_dig_d;
        end
    end

    assign rem_d1 = rem_dig_q[7:4];
    assign rem_d0 = rem_dig_q[3:0];
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: directed key sequences, results checked on res_valid.
module tb_calc_seq_ctrl;

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_MUL = 4'd12;
    localparam logic [3:0] K_DIV = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14;
    localparam logic [3:0] K_CLR = 4'd15;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] res_d3, res_d2, res_d1, res_d0;
    logic       res_neg, res_valid, err, busy;
`ifdef CALC_REMAINDER_EN
    logic [3:0] rem_d1, rem_d0;
`endif

    calc_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .res_d3   (res_d3),
        .res_d2   (res_d2),
        .res_d1   (res_d1),
        .res_d0   (res_d0),
        .res_neg  (res_neg),
        .res_valid(res_valid),
        .err      (err),
        .busy     (busy)
`ifdef CALC_REMAINDER_EN
        ,
        .rem_d1   (rem_d1),
        .rem_d0   (rem_d0)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dig;
        logic        neg;
        logic [7:0]  rem;
        int          lat;
        int          t_eq;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_t = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic int digits();
        return int'({res_d3, res_d2, res_d1, res_d0});
    endfunction

    task automatic send_key(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        last_t    = cyc;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic eq_expect(input string name, input logic [15:0] dig, input logic neg,
                             input logic [7:0] rem, input int lat);
        exp_t e;
        send_key(K_EQ);
        e.dig  = dig;
        e.neg  = neg;
        e.rem  = rem;
        e.lat  = lat;
        e.t_eq = last_t;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_ready !== 1'b1 && n < 60);
        if (key_ready !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    // Monitor: every res_valid pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_digits"}, digits(), int'(e.dig));
                    check({e.name, "_neg"}, int'(res_neg), int'(e.neg));
                    check({e.name, "_latency"}, cyc - e.t_eq, e.lat);
`ifdef CALC_REMAINDER_EN
                    check({e.name, "_rem"}, int'({rem_d1, rem_d0}), int'(e.rem));
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_digits", digits(), 0);
        check("reset_neg", int'(res_neg), 0);
        check("reset_valid", int'(res_valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(key_ready), 1);

        // 12 + 23
        send_key(4'd1); send_key(4'd2); send_key(K_ADD); send_key(4'd2); send_key(4'd3);
        eq_expect("add_12_23", 16'h0035, 1'b0, 8'h00, 16);
        wait_ready("add_12_23");

        // 99 * 99, with a digit key pushed while busy
        send_key(4'd9); send_key(4'd9); send_key(K_MUL); send_key(4'd9); send_key(4'd9);
        eq_expect("mul_99_99", 16'h9801, 1'b0, 8'h00, 16);
        @(negedge clk);
        check("busy_ready_low", int'(key_ready), 0);
        check("busy_high", int'(busy), 1);
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_ready("mul_99_99");

        // 12 - 23 is negative, then 45 + 5
        send_key(4'd1); send_key(4'd2); send_key(K_SUB); send_key(4'd2); send_key(4'd3);
        eq_expect("sub_12_23", 16'h0011, 1'b1, 8'h00, 16);
        wait_ready("sub_12_23");
        send_key(4'd4); send_key(4'd5); send_key(K_ADD); send_key(4'd5);
        eq_expect("add_45_5", 16'h0050, 1'b0, 8'h00, 16);
        wait_ready("add_45_5");

        // 84 / 5 = 16 r 4
        send_key(4'd8); send_key(4'd4); send_key(K_DIV); send_key(4'd5);
        eq_expect("div_84_5", 16'h0016, 1'b0, 8'h04, 22);
        wait_ready("div_84_5");

        // 7 / 0 -> error, digits ignored, clear recovers
        send_key(4'd7); send_key(K_DIV); send_key(4'd0); send_key(K_EQ);
        wait_ready("div_by_zero");
        check("err_set", int'(err), 1);
        check("err_digits_zero", digits(), 0);
        check("err_not_busy", int'(busy), 0);
        send_key(4'd3);
        @(negedge clk);
        check("err_held_after_digit", int'(err), 1);
        check("err_ready", int'(key_ready), 1);
        send_key(K_CLR);
        @(negedge clk);
        check("clear_err", int'(err), 0);
        check("clear_ready", int'(key_ready), 1);

        // third digit ignored: 12 + 4, then chained * 9
        send_key(4'd1); send_key(4'd2); send_key(4'd3); send_key(K_ADD); send_key(4'd4);
        eq_expect("add_12_4", 16'h0016, 1'b0, 8'h00, 16);
        wait_ready("add_12_4");
        send_key(K_MUL); send_key(4'd9);
        eq_expect("chain_mul_9", 16'h0144, 1'b0, 8'h00, 16);
        wait_ready("chain_mul_9");

        // rst during CONV: no result, everything back to zero
        send_key(4'd5); send_key(K_ADD); send_key(4'd5); send_key(K_EQ);
        repeat (6) @(negedge clk);
        check("mid_conv_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_digits", digits(), 0);
        check("rst_abort_busy", int'(busy), 0);
        check("rst_abort_ready", int'(key_ready), 1);
        check("rst_abort_valid", int'(res_valid), 0);
        repeat (20) @(negedge clk);
        send_key(4'd2); send_key(K_MUL); send_key(4'd3);
        eq_expect("mul_2_3", 16'h0006, 1'b0, 8'h00, 16);
        wait_ready("mul_2_3");

        // clear during CALC of a divide
        send_key(4'd9); send_key(K_DIV); send_key(4'd2); send_key(K_EQ);
        @(negedge clk);
        check("mid_calc_busy", int'(busy), 1);
        send_key(K_CLR);
        @(negedge clk);
        check("clr_abort_busy", int'(busy), 0);
        check("clr_abort_ready", int'(key_ready), 1);
        check("clr_abort_digits", digits(), 0);
        repeat (30) @(negedge clk);

        // 99 / 7 = 14 r 1
        send_key(4'd9); send_key(4'd9); send_key(K_DIV); send_key(4'd7);
        eq_expect("div_99_7", 16'h0014, 1'b0, 8'h01, 22);
        wait_ready("div_99_7");

        repeat (30) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Sequencing controller for the two-digit decimal calculator. Accepts a keypad stream: operand A digits, operator, operand B digits, equals. Joins digits into binary operands, runs one of add/sub/mul/div on a shared datapath (iterative divider), and converts the binary result to four BCD display digits with an iterative binary-to-BCD converter. Sits between the keypad decoder and the display driver.

Parameters:
OPD_W, 7, operand width (0..99)
RES_W, 14, result width (0..9801)
BCD_N, 4, result BCD digits

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_valid  in  1  key strobe, qualified by key_ready
key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
key_ready  out  1  controller accepts keys (high in ENT_A/ENT_B/DONE/ERR)
res_d3..res_d0  out  4 each  result BCD digits, d3 = thousands
res_neg  out  1  subtraction result negative (digits hold magnitude)
res_valid  out  1  one-cycle pulse on entry to DONE
err  out  1  divide by zero, held in ERR
busy  out  1  high in CALC/CONV

Behaviour:
- Key accepted when key_valid & key_ready at a rising edge; clear (15) accepted in any state, even with key_ready low, and returns to ENT_A with all registers zeroed in the next cycle.
- Reset: state ENT_A; opa/opb/op/result zero; res_d* 0, res_neg 0, res_valid 0, err 0, busy 0, key_ready 1.
- States: ENT_A, ENT_B, CALC, CONV, DONE, ERR.
- ENT_A: digit -> opa = opa*10 + d if fewer than 2 digits entered, else ignored. Operator -> latch op, go ENT_B (operator with no digits entered means opa = 0). Equals ignored.
- ENT_B: digit -> opb, same rule. A further operator overwrites op. Equals -> CALC.
- CALC: add/sub/mul take 1 cycle. Sub: if opa < opb then result = opb-opa and res_neg = 1. Div: if opb = 0 -> ERR (err = 1, res_d* = 0). Otherwise restoring shift-subtract division for exactly OPD_W = 7 cycles; quotient becomes result.
- CONV: double-dabble over RES_W = 14 cycles, then DONE.
- Latency: equals accepted in cycle T -> res_valid high in cycle T+16 (add/sub/mul) or T+22 (div).
- DONE: digits and res_neg held. Digit key -> start a new ENT_A with that digit as the first opa digit. Operator key -> chain: opa = previous result if result <= 99, else ERR. All outputs keep their values until the next CALC.
- ERR: only clear (or rst) exits. Other keys are accepted and dropped.
- Keys arriving while key_ready = 0 (except clear) are dropped. The upstream block must hold key_valid until accepted or discard the key.
- rst mid-CALC/CONV aborts immediately to the reset state. No partial result is shown.

Optional Feature:
CALC_REMAINDER_EN
- Defined: adds port rem_d1..rem_d0 (out, 4 each) holding the division remainder as two BCD digits. These are valid with res_valid and are zero for non-div ops and for ERR. Remainder conversion runs in parallel with CONV, so latency is unchanged.
- Undefined: the ports are absent and no remainder logic is built.

Decomposition:
- Package calc_pkg: key code constants (KEY_ADD..KEY_CLR), op enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), state enum, and OPD_W/RES_W/BCD_N defaults.
- One sub-module, calc_bin2bcd: iterative double-dabble converter with start/done handshake, RES_W-cycle run, BCD_N digit outputs.
- Join arithmetic (x*10+d), the ALU and the divider stay inline in calc_seq_ctrl.

Test Plan:
- Keys 1,2,add,2,3,equals -> res_valid at T+16, digits 0,0,3,5, res_neg 0.
- 9,9,mul,9,9,equals -> digits 9,8,0,1. Keys sent during busy are dropped and key_ready is 0.
- 1,2,sub,2,3,equals -> digits 0,0,1,1, res_neg 1. Then 4,5,add,5,equals -> 0,0,5,0, res_neg 0.
- 8,4,div,5,equals -> 0,0,1,6 at T+22 (with CALC_REMAINDER_EN: rem 0,4). Then 7,div,0,equals -> err 1. Digit keys ignored; clear -> ENT_A, err 0.
- 1,2,3,add,4,equals -> opa 12, result 0,0,1,6. Then chained mul,9,equals -> 0,1,4,4.
- rst asserted mid-CONV -> next cycle all outputs zero, state ENT_A. Clear mid-CALC -> ENT_A, no res_valid pulse.
